// File: rtl/wam_bin2bcd.sv
// rtl/wam_bin2bcd.sv - sequential double-dabble binary-to-BCD converter
// One bit per clock with start/busy/done handshake, leading-zero blank mask and overflow flag.
module wam_bin2bcd #(
  parameter int W      = 12,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [W-1:0]        bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   blank,
  output logic                ovf
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0]     LAST_CNT  = CW'(W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_next;
  logic [W-1:0]    shreg;
  logic [BW-1:0]   scratch, corrected, scratch_next;
  logic [CW-1:0]   cnt;
  logic            ovf_acc, shout, last, zero_run;
  logic [DIGITS-1:0] blank_next;

  always_comb begin
    corrected = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) corrected[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
    shout        = corrected[BW-1];
    scratch_next = {corrected[BW-2:0], shreg[W-1]};
    last         = (cnt == LAST_CNT);

    // blank[k] is set while every digit from the top down to k is zero
    zero_run   = 1'b1;
    blank_next = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run & (scratch_next[4*k +: 4] == 4'd0);
      blank_next[k] = zero_run;
    end

    state_next = state;
    case (state)
      IDLE:  if (start) state_next = SHIFT;
      SHIFT: if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      blank   <= BLANK_RST;
      ovf     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          shreg   <= {shreg[W-2:0], 1'b0};
          ovf_acc <= ovf_acc | shout;
          cnt     <= cnt + CW'(1);
          if (last) begin
            bcd   <= scratch_next;
            ovf   <= ovf_acc | shout;
            blank <= blank_next;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wam_bin2bcd.sv
// tb/tb_wam_bin2bcd.sv - randomized self-checking bench for wam_bin2bcd
// Two instances: default 4-digit and a 3-digit one for overflow behaviour.
module tb_wam_bin2bcd;

  logic        clk = 1'b0;
  logic        clr;
  logic        start, start3;
  logic [11:0] bin, bin3;
  logic        busy, done, ovf, busy3, done3, ovf3;
  logic [15:0] bcd;
  logic [11:0] bcd3;
  logic [3:0]  blank;
  logic [2:0]  blank3;

  int checks = 0;
  int failures = 0;

  wam_bin2bcd #(.W(12), .DIGITS(4)) dut (
    .clk(clk), .clr(clr), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank), .ovf(ovf)
  );

  wam_bin2bcd #(.W(12), .DIGITS(3)) dut3 (
    .clk(clk), .clr(clr), .start(start3), .bin(bin3),
    .busy(busy3), .done(done3), .bcd(bcd3), .blank(blank3), .ovf(ovf3)
  );

  always #5 clk = ~clk;

  function automatic int pow10(int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] ref_bcd(int v, int d);
    logic [15:0] r = '0;
    int x = v % pow10(d);
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_blank(int v, int d);
    logic [3:0] b = '0;
    int x = v % pow10(d);
    for (int k = 1; k < d; k++) b[k] = (x < pow10(k));
    return b;
  endfunction

  function automatic logic ref_ovf(int v, int d);
    return v >= pow10(d);
  endfunction

  task automatic convert(input bit sel3, input int v, output int lat,
                         output logic [15:0] got_bcd, output logic [3:0] got_blank,
                         output logic got_ovf, output logic got_busy);
    @(negedge clk);
    if (sel3) begin start3 = 1'b1; bin3 = 12'(v); end
    else      begin start  = 1'b1; bin  = 12'(v); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
    bin = 12'($urandom); bin3 = 12'($urandom);
    got_busy = sel3 ? busy3 : busy;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel3 ? done3 : done) begin
        lat = i;
        break;
      end
    end
    got_bcd   = sel3 ? {4'd0, bcd3} : bcd;
    got_blank = sel3 ? {1'b0, blank3} : blank;
    got_ovf   = sel3 ? ovf3 : ovf;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; start3 = 1'b0; bin = '0; bin3 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bcd, ovf} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b bcd=%h ovf=%b expected all zero", busy, done, bcd, ovf);
    end
    checks++;
    if (blank !== 4'b1110 || blank3 !== 3'b110) begin
      failures++;
      $display("FAIL reset_blank got=%b/%b expected=1110/110", blank, blank3);
    end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_values(input string name, input int v);
    int lat; logic [15:0] b; logic [3:0] bl; logic o, bz;
    convert(1'b0, v, lat, b, bl, o, bz);
    checks++;
    if (lat !== 12) begin
      failures++;
      $display("FAIL %s_latency v=%0d got=%0d expected=12", name, v, lat);
    end
    checks++;
    if (bz !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy v=%0d got=%b expected=1", name, v, bz);
    end
    checks++;
    if (b !== ref_bcd(v, 4) || bl !== ref_blank(v, 4) || o !== ref_ovf(v, 4)) begin
      failures++;
      $display("FAIL %s_result v=%0d got bcd=%h blank=%b ovf=%b expected bcd=%h blank=%b ovf=%b",
               name, v, b, bl, o, ref_bcd(v, 4), ref_blank(v, 4), ref_ovf(v, 4));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bcd !== ref_bcd(v, 4)) begin
      failures++;
      $display("FAIL %s_hold v=%0d got done=%b bcd=%h expected done=0 bcd=%h", name, v, done, bcd, ref_bcd(v, 4));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) test_values("random", int'($urandom_range(0, 4095)));
  endtask

  task automatic test_start_while_busy();
    int first = -1, second = -1, ndone = 0;
    logic [15:0] bcd_first = '0, bcd_second = '0;
    @(negedge clk);
    start = 1'b1; bin = 12'd123;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5) || (first > 0 && c == first + 1);
      bin = (c == 5) ? 12'd999 : 12'd7;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) begin first = c; bcd_first = bcd; end
        else begin second = c; bcd_second = bcd; end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 2 || first !== 12) begin
      failures++;
      $display("FAIL busy_ignore dones=%0d first_at=%0d expected dones=2 first_at=12", ndone, first);
    end
    checks++;
    if (bcd_first !== 16'h0123) begin
      failures++;
      $display("FAIL busy_ignore_bcd got=%h expected=0123", bcd_first);
    end
    checks++;
    if (second - first !== 13 || bcd_second !== 16'h0007) begin
      failures++;
      $display("FAIL back_to_back gap=%0d bcd=%h expected gap=13 bcd=0007", second - first, bcd_second);
    end
  endtask

  task automatic test_clr_abort();
    int ndone = 0, lat; logic [15:0] b; logic [3:0] bl; logic o, bz; int v;
    @(negedge clk);
    start = 1'b1; bin = 12'd555;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || bcd !== 16'h0000 || done !== 1'b0 || blank !== 4'b1110) begin
      failures++;
      $display("FAIL clr_abort busy=%b bcd=%h done=%b blank=%b expected 0/0000/0/1110", busy, bcd, done, blank);
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL clr_no_done got=%0d expected=0", ndone);
    end
    v = int'($urandom_range(0, 4095));
    convert(1'b0, v, lat, b, bl, o, bz);
    checks++;
    if (lat !== 12 || b !== ref_bcd(v, 4) || bl !== ref_blank(v, 4)) begin
      failures++;
      $display("FAIL clr_restart v=%0d got lat=%0d bcd=%h blank=%b expected lat=12 bcd=%h blank=%b",
               v, lat, b, bl, ref_bcd(v, 4), ref_blank(v, 4));
    end
  endtask

  task automatic test_digits3();
    int vals[6];
    int lat; logic [15:0] b; logic [3:0] bl; logic o, bz;
    vals[0] = 1000; vals[1] = 999; vals[2] = 4095;
    vals[3] = int'($urandom_range(1000, 4095));
    vals[4] = int'($urandom_range(0, 999));
    vals[5] = 7;
    foreach (vals[i]) begin
      convert(1'b1, vals[i], lat, b, bl, o, bz);
      checks++;
      if (lat !== 12 || b !== ref_bcd(vals[i], 3) || bl !== ref_blank(vals[i], 3) || o !== ref_ovf(vals[i], 3)) begin
        failures++;
        $display("FAIL digits3 v=%0d got lat=%0d bcd=%h blank=%b ovf=%b expected lat=12 bcd=%h blank=%b ovf=%b",
                 vals[i], lat, b, bl, o, ref_bcd(vals[i], 3), ref_blank(vals[i], 3), ref_ovf(vals[i], 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_values("zero", 0);
    test_values("max_score", 2997);
    test_values("full_scale", 4095);
    test_values("thirty", 30);
    test_random();
    test_start_while_busy();
    test_clr_abort();
    test_digits3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
